// File: rtl/boot_rom_arb.sv
// boot_rom_arb: shares a single-ported, registered-read boot ROM between the
// instruction-fetch port (port 0) and a data-load port (port 1).
//
// Handshake semantics (both directions, both ports): a transfer happens on a
// rising edge where valid and ready are both high. A requester holds req_vld
// and its address stable until req_rdy; dropping req_vld earlier withdraws the
// request. A response (rsp_vld, rsp_data, rsp_err) stays stable until the
// owning port's rsp_rdy is seen high at a rising edge.
//
// Only one transaction is in flight. Ties are broken round-robin using the
// last-granted port; invalid addresses are answered with rsp_err=1 and data 0
// without touching the ROM.
module boot_rom_arb #(
    parameter int ROM_DEPTH = 14,
    parameter int ROM_AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_vld,
    input  logic [31:0]       req_addr0,
    input  logic [31:0]       req_addr1,
    output logic [1:0]        req_rdy,
    output logic [1:0]        rsp_vld,
    input  logic [1:0]        rsp_rdy,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ROM_DEPTH widened by one bit so an index compare cannot overflow.
    localparam logic [ROM_AW:0] DEPTH_L = (ROM_AW + 1)'(ROM_DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic               r_lg;
    logic               r_port;
    logic [31:0]        r_data;
    logic               r_err;

    logic               w_accept;
    logic               w_gnt_port;
    logic [31:0]        w_addr;
    logic [ROM_AW-1:0]  w_idx;
    logic               w_dec_err;

    // Arbitration and address decode of the candidate winner.
    always_comb begin
        w_accept = (r_state == S_IDLE) && (req_vld != 2'b00);
        if (req_vld == 2'b11) begin
            w_gnt_port = ~r_lg;
        end else begin
            w_gnt_port = req_vld[1];
        end
        w_addr    = w_gnt_port ? req_addr1 : req_addr0;
        w_idx     = w_addr[ROM_AW+1:2];
        w_dec_err = (w_addr[1:0] != 2'b00)
                 || (w_addr[31:ROM_AW+2] != '0)
                 || ({1'b0, w_idx} >= DEPTH_L);
    end

    // Next-state logic and all handshake / ROM-side outputs.
    always_comb begin
        w_next   = r_state;
        req_rdy  = 2'b00;
        rsp_vld  = 2'b00;
        rom_cs   = 1'b0;
        rom_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_rdy = w_gnt_port ? 2'b10 : 2'b01;
                    if (w_dec_err) begin
                        w_next = S_RESP;
                    end else begin
                        rom_cs   = 1'b1;
                        rom_addr = w_idx;
                        w_next   = S_READ;
                    end
                end
            end
            S_READ: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_vld = r_port ? 2'b10 : 2'b01;
                if (rsp_rdy[r_port]) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register, grant pointer and the held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lg    <= 1'b1;
            r_port  <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lg   <= w_gnt_port;
                r_port <= w_gnt_port;
                r_err  <= w_dec_err;
                r_data <= '0;
            end
            if (r_state == S_READ) begin
                r_data <= rom_data;
                r_err  <= 1'b0;
            end
        end
    end

    assign rsp_data  = r_data;
    assign rsp_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_boot_rom_arb.sv
// tb_boot_rom_arb: directed and randomized checks of boot_rom_arb against a
// transaction-level reference model (grant rules, decode rules, response queue).
module tb_boot_rom_arb;

    localparam int DEPTH = 14;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_vld;
    logic [31:0]   req_addr0;
    logic [31:0]   req_addr1;
    logic [1:0]    req_rdy;
    logic [1:0]    rsp_vld;
    logic [1:0]    rsp_rdy;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data = '0;
    logic [1:0]    dbg_state;

    logic [31:0]   rom_mem [16];
    logic [33:0]   exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_acc    = 0;
    int            n_rsp    = 0;
    logic          m_busy   = 1'b0;
    logic          m_lg     = 1'b1;
    int            m_age    = 0;

    boot_rom_arb #(.ROM_DEPTH(DEPTH), .ROM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
        .dbg_state(dbg_state)
    );

    // Clock and registered-read ROM model.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_cs) rom_data <= rom_mem[rom_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic ref_err(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || (a >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] a);
        if (ref_err(a)) return 32'd0;
        return rom_mem[a / 32'd4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_vld = 2'b00; rsp_rdy = 2'b00;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One full transaction from an idle arbiter, with latency checks.
    task automatic txn(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                       input int gp, input logic exp_err, input logic [31:0] exp_data);
        logic [31:0] a;
        a = (gp == 1) ? a1 : a0;
        req_vld = vld; req_addr0 = a0; req_addr1 = a1; rsp_rdy = 2'b11;
        @(negedge clk);
        chk("acc_req_rdy", 32'(req_rdy), 32'(1) << gp);
        chk("acc_rom_cs", 32'(rom_cs), 32'(!exp_err));
        if (!exp_err) chk("acc_rom_addr", 32'(rom_addr), a / 32'd4);
        tick();
        req_vld = vld & ~(2'(1) << gp);
        if (!exp_err) begin
            @(negedge clk);
            chk("read_rsp_vld", 32'(rsp_vld), 32'd0);
            chk("read_req_rdy", 32'(req_rdy), 32'd0);
            chk("read_rom_cs", 32'(rom_cs), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("resp_rsp_vld", 32'(rsp_vld), 32'(1) << gp);
        chk("resp_data", rsp_data, exp_data);
        chk("resp_err", 32'(rsp_err), 32'(exp_err));
        chk("resp_req_rdy", 32'(req_rdy), 32'd0);
        chk("resp_rom_cs", 32'(rom_cs), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return 32'($urandom_range(0, 15)) * 32'd4;
        if (r == 6) return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
        if (r == 7) return $urandom() | 32'h0000_0100;
        if (r == 8) return $urandom();
        return 32'(4 * DEPTH);
    endfunction

    // One random cycle checked against the transaction model.
    task automatic rnd_cycle(input bit allow_new);
        int          gp;
        logic [1:0]  exp_rdy;
        logic [33:0] head;
        int          lat;
        logic [31:0] a;
        logic        cleared;
        @(negedge clk);
        if (m_busy) m_age++;
        exp_rdy = 2'b00;
        gp = 0;
        if (!m_busy && req_vld != 2'b00) begin
            if (req_vld == 2'b11) gp = m_lg ? 0 : 1;
            else gp = req_vld[1] ? 1 : 0;
            exp_rdy = 2'(1) << gp;
        end
        chk("rnd_req_rdy", 32'(req_rdy), 32'(exp_rdy));
        if (m_busy) begin
            head = exp_q[0];
            lat = head[32] ? 1 : 2;
            if (m_age >= lat) begin
                chk("rnd_rsp_vld", 32'(rsp_vld), 32'(1) << head[33]);
                chk("rnd_rsp_data", rsp_data, head[31:0]);
                chk("rnd_rsp_err", 32'(rsp_err), 32'(head[32]));
                if (rsp_rdy[head[33]]) begin
                    void'(exp_q.pop_front());
                    n_rsp++;
                    m_busy = 1'b0;
                end
            end else begin
                chk("rnd_rsp_early", 32'(rsp_vld), 32'd0);
            end
        end else begin
            chk("rnd_rsp_idle", 32'(rsp_vld), 32'd0);
        end
        if (exp_rdy != 2'b00) begin
            a = (gp == 1) ? req_addr1 : req_addr0;
            chk("rnd_rom_cs", 32'(rom_cs), 32'(!ref_err(a)));
            if (!ref_err(a)) chk("rnd_rom_addr", 32'(rom_addr), a / 32'd4);
            exp_q.push_back({1'(gp), ref_err(a), ref_data(a)});
            n_acc++;
            m_busy = 1'b1;
            m_age  = 0;
            m_lg   = 1'(gp);
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            cleared = 1'b0;
            if (req_vld[p] && (exp_rdy[p] || !allow_new || $urandom_range(0, 15) == 0)) begin
                req_vld[p] = 1'b0;
                cleared = 1'b1;
            end
            if (allow_new && !req_vld[p] && !cleared && $urandom_range(0, 2) == 0) begin
                req_vld[p] = 1'b1;
                if (p == 0) req_addr0 = rand_addr();
                else        req_addr1 = rand_addr();
            end
        end
        rsp_rdy = allow_new ? 2'($urandom_range(0, 3)) : 2'b11;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 32'h5a00_0000 | 32'(i * 32'h0101);
        rom_mem[0]  = 32'h8000_00b7;
        rom_mem[1]  = 32'h1000_0137;
        rom_mem[13] = 32'h0003_80e7;
        req_addr0 = '0; req_addr1 = '0;

        // Reset values
        rst = 1'b1; req_vld = 2'b00; rsp_rdy = 2'b00;
        tick(); tick();
        @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        tick();
        rst = 1'b0;

        // Single fetch
        txn(2'b01, 32'h0, 32'h0, 0, 1'b0, 32'h8000_00b7);

        // Ties from reset: port 0, then alternating
        do_reset();
        txn(2'b11, 32'h4, 32'h34, 0, 1'b0, 32'h1000_0137);
        txn(2'b11, 32'h0, 32'h34, 1, 1'b0, 32'h0003_80e7);
        txn(2'b11, 32'h0, 32'h30, 0, 1'b0, 32'h8000_00b7);
        txn(2'b10, 32'h0, 32'h30, 1, 1'b0, rom_mem[12]);

        // Decode errors and boundaries
        txn(2'b10, 32'h0, 32'h38, 1, 1'b1, 32'h0);
        txn(2'b01, 32'h6, 32'h0, 0, 1'b1, 32'h0);
        txn(2'b10, 32'h0, 32'h8000_0000, 1, 1'b1, 32'h0);
        txn(2'b01, 32'h3c, 32'h0, 0, 1'b1, 32'h0);
        txn(2'b10, 32'h0, 32'h40, 1, 1'b1, 32'h0);
        txn(2'b01, 32'h34, 32'h0, 0, 1'b0, 32'h0003_80e7);

        // Backpressure with port 1 waiting; port 1's rsp_rdy must not release port 0
        req_vld = 2'b01; req_addr0 = 32'h8; rsp_rdy = 2'b00;
        @(negedge clk);
        chk("bp_acc", 32'(req_rdy), 32'd1);
        tick();
        req_vld = 2'b10; req_addr1 = 32'hc; rsp_rdy = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
            chk("bp_rsp_data", rsp_data, rom_mem[2]);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            chk("bp_req_rdy", 32'(req_rdy), 32'd0);
            tick();
        end
        rsp_rdy = 2'b01;
        @(negedge clk);
        chk("bp_release_vld", 32'(rsp_vld), 32'd1);
        tick();
        rsp_rdy = 2'b11;
        @(negedge clk);
        chk("bp_next_acc", 32'(req_rdy), 32'd2);
        chk("bp_next_rom_addr", 32'(rom_addr), 32'd3);
        tick();
        req_vld = 2'b00;
        tick();
        @(negedge clk);
        chk("bp_next_vld", 32'(rsp_vld), 32'd2);
        chk("bp_next_data", rsp_data, rom_mem[3]);
        tick();

        // Reset while in READ
        req_vld = 2'b01; req_addr0 = 32'h4;
        @(negedge clk);
        chk("rr_acc", 32'(req_rdy), 32'd1);
        tick();
        req_vld = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_rsp_vld", 32'(rsp_vld), 32'd0);
            chk("rr_rsp_data", rsp_data, 32'd0);
            chk("rr_rsp_err", 32'(rsp_err), 32'd0);
            chk("rr_rom_cs", 32'(rom_cs), 32'd0);
            chk("rr_rom_addr", 32'(rom_addr), 32'd0);
            chk("rr_req_rdy", 32'(req_rdy), 32'd0);
            tick();
        end
        txn(2'b11, 32'h4, 32'h0, 0, 1'b0, 32'h1000_0137);

        // Random stress against the model
        do_reset();
        m_lg = 1'b1; m_busy = 1'b0; exp_q.delete();
        for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 8; c++) rnd_cycle(1'b0);
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_acc_vs_rsp", 32'(n_rsp), 32'(n_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
